instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 187 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//    Serialises one Y86-64 instruction (icode/ifun/rA/rB/valC) into its byte
//    image and writes it, one byte per clock, into a byte-wide memory starting
//    at the current write pointer. After a successful instruction the pointer
//    (next_addr) advances to the instruction's valP. Invalid icodes and
//    instructions that would run past address 1023 are accepted but dropped,
//    with a one-cycle error pulse.
//
// Ports:
//    clk, rst_n                 rising-edge clock, asynchronous active-low reset
//    in_valid / in_ready        request handshake (accept when both high)
//    in_icode, in_ifun          opcode nibbles, byte 0
//    in_rA, in_rB               register nibbles, byte 1 when present
//    in_valC                    64-bit constant
//    addr_load, addr_in         load the write pointer (IDLE only)
//    mem_we, mem_addr, mem_wdata  registered byte-write port
//    next_addr                  write pointer (valP of the last instruction)
//    done, done_len             pulse on the last byte, with the byte count
//    err_icode, err_ovf         one-cycle error pulses
//
// Configuration macro:
//    INSTR_ENC_LITTLE_ENDIAN_EN  defined   -> valC written least-significant
//                                             byte first (standard Y86-64)
//                                undefined -> valC written most-significant
//                                             byte first (fetch-stage order)
// -----------------------------------------------------------------------------
module instr_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_icode,
   input  logic [3:0]  in_ifun,
   input  logic [3:0]  in_rA,
   input  logic [3:0]  in_rB,
   input  logic [63:0] in_valC,
   input  logic        addr_load,
   input  logic [9:0]  addr_in,
   output logic        mem_we,
   output logic [9:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   output logic [9:0]  next_addr,
   output logic        done,
   output logic [3:0]  done_len,
   output logic        err_icode,
   output logic        err_ovf
);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t      state_reg;
   logic [3:0]  rA_reg;
   logic [3:0]  rB_reg;
   logic [63:0] valC_reg;
   logic        is_jc_reg;   // jXX / call: valC follows byte 0 directly
   logic [3:0]  len_reg;
   logic [9:0]  ptr_reg;
   logic [3:0]  cnt_reg;     // index of the next byte to write

   // Instruction length from icode; 0 marks an invalid icode.
   function automatic logic [3:0] len_of(input logic [3:0] icode);
      logic [3:0] len;
      case (icode)
         4'h0, 4'h1, 4'h9:        len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB:  len = 4'd2;
         4'h3, 4'h4, 4'h5:        len = 4'd10;
         4'h7, 4'h8:              len = 4'd9;
         default:                 len = 4'd0;
      endcase
      return len;
   endfunction

   logic [3:0] in_len;
   logic       in_bad_icode;
   logic       in_ovf;

   assign in_len       = len_of(in_icode);
   assign in_bad_icode = (in_icode > 4'hB);
   // Last byte address is pointer+L-1; overflow when that exceeds 1023,
   // i.e. pointer+L > 1024. Evaluated in 11 bits so nothing wraps.
   assign in_ovf       = (({1'b0, next_addr} + {7'd0, in_len}) > 11'd1024);

   assign in_ready = (state_reg == IDLE) && !addr_load;

   // valC byte j in emission order (j = 0 is the first valC byte written).
   logic [7:0] valc_byte [8];
   for (genvar gi = 0; gi < 8; gi++) begin : g_valc
`ifdef INSTR_ENC_LITTLE_ENDIAN_EN
      assign valc_byte[gi] = valC_reg[8*gi +: 8];
`else
      assign valc_byte[gi] = valC_reg[8*(7-gi) +: 8];
`endif
   end

   // Byte for position cnt_reg (>= 1). The 3-bit index works modulo 8:
   // jXX/call map bytes 1..8 to valC 0..7, the 10-byte forms map 2..9.
   logic [2:0] vidx;
   logic [7:0] cur_byte;
   always_comb begin
      vidx     = is_jc_reg ? (cnt_reg[2:0] - 3'd1) : (cnt_reg[2:0] - 3'd2);
      cur_byte = {rA_reg, rB_reg};
      if (is_jc_reg || (cnt_reg >= 4'd2))
         cur_byte = valc_byte[vidx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         next_addr <= 10'd0;
         mem_we    <= 1'b0;
         mem_addr  <= 10'd0;
         mem_wdata <= 8'd0;
         done      <= 1'b0;
         done_len  <= 4'd0;
         err_icode <= 1'b0;
         err_ovf   <= 1'b0;
         rA_reg    <= 4'd0;
         rB_reg    <= 4'd0;
         valC_reg  <= 64'd0;
         is_jc_reg <= 1'b0;
         len_reg   <= 4'd0;
         ptr_reg   <= 10'd0;
         cnt_reg   <= 4'd0;
      end else begin
         // Pulses default low; mem_addr/mem_wdata keep their last value.
         mem_we    <= 1'b0;
         done      <= 1'b0;
         err_icode <= 1'b0;
         err_ovf   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (addr_load) begin
                  next_addr <= addr_in;
               end else if (in_valid) begin
                  if (in_bad_icode) begin
                     err_icode <= 1'b1;
                  end else if (in_ovf) begin
                     err_ovf <= 1'b1;
                  end else begin
                     rA_reg    <= in_rA;
                     rB_reg    <= in_rB;
                     valC_reg  <= in_valC;
                     is_jc_reg <= (in_icode == 4'h7) || (in_icode == 4'h8);
                     len_reg   <= in_len;
                     ptr_reg   <= next_addr;
                     // Byte 0 goes out on the acceptance edge so the first
                     // write is visible the cycle after acceptance.
                     mem_we    <= 1'b1;
                     mem_addr  <= next_addr;
                     mem_wdata <= {in_icode, in_ifun};
                     cnt_reg   <= 4'd1;
                     state_reg <= EMIT;
                     if (in_len == 4'd1) begin
                        done      <= 1'b1;
                        done_len  <= in_len;
                        next_addr <= next_addr + 10'd1;
                     end
                  end
               end
            end
            EMIT: begin
               if (cnt_reg < len_reg) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= ptr_reg + {6'd0, cnt_reg};
                  mem_wdata <= cur_byte;
                  cnt_reg   <= cnt_reg + 4'd1;
                  if (cnt_reg == (len_reg - 4'd1)) begin
                     done      <= 1'b1;
                     done_len  <= len_reg;
                     // An instruction ending exactly at 1023 leaves valP=1024,
                     // which a 10-bit pointer shows as 0.
                     next_addr <= ptr_reg + {6'd0, len_reg};
                  end
               end else begin
                  // Last byte went out the previous cycle.
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
   logic [63:0] in_valC;
   logic        addr_load;
   logic [9:0]  addr_in;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [9:0]  next_addr;
   logic        done;
   logic [3:0]  done_len;
   logic        err_icode;
   logic        err_ovf;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
      .in_valC(in_valC),
      .addr_load(addr_load), .addr_in(addr_in),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .next_addr(next_addr), .done(done), .done_len(done_len),
      .err_icode(err_icode), .err_ovf(err_ovf)
   );

   localparam int K_OK   = 0;
   localparam int K_ICOD = 1;
   localparam int K_OVF  = 2;

   typedef struct {
      logic [3:0]  icode, ifun, ra, rb;
      logic [63:0] valc;
      logic        do_load;
      logic [9:0]  load_addr;
      int          exp_len;
      int          exp_kind;
   } vec_t;

   typedef struct {
      logic [9:0] addr;
      logic [7:0] data;
   } wr_t;

   vec_t vecs [19];
   wr_t  exp_q [$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   wr_count = 0;
   logic [9:0] model_next = 10'd0;

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   // Scoreboard consumer: every byte the DUT writes must be the next one expected.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && mem_we === 1'b1) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                     mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {54'd0, mem_addr}, {54'd0, e.addr});
            chk("wr_data", {56'd0, mem_wdata}, {56'd0, e.data});
            $display("write addr=0x%03h data=0x%02h", mem_addr, mem_wdata);
         end
      end
   end

   // Reference byte image of an instruction, built from the encoding rules.
   task automatic push_expected(input vec_t v, input logic [9:0] base);
      logic [7:0] b [10];
      int idx;
      wr_t w;
      b[0] = {v.icode, v.ifun};
      idx = 1;
      if (v.exp_len == 2 || v.exp_len == 10) begin
         b[1] = {v.ra, v.rb};
         idx = 2;
      end
      if (v.exp_len >= 9) begin
         for (int j = 0; j < 8; j++) begin
`ifdef INSTR_ENC_LITTLE_ENDIAN_EN
            b[idx+j] = v.valc[8*j +: 8];
`else
            b[idx+j] = v.valc[8*(7-j) +: 8];
`endif
         end
      end
      for (int k = 0; k < v.exp_len; k++) begin
         w.addr = base + 10'(k);
         w.data = b[k];
         exp_q.push_back(w);
      end
   endtask

   task automatic do_addr_load(input logic [9:0] a);
      @(negedge clk);
      addr_load = 1'b1;
      addr_in   = a;
      in_valid  = 1'b1;          // must lose to addr_load
      in_icode  = 4'h1; in_ifun = 4'h0;
      #1;
      chk("ready_low_on_load", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      addr_load = 1'b0;
      in_valid  = 1'b0;
      chk("load_next_addr", {54'd0, next_addr}, {54'd0, a});
      model_next = a;
      $display("addr_load 0x%03h next_addr=0x%03h", a, next_addr);
   endtask

   task automatic run_instr(input vec_t v);
      int cycles;
      wr_count = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_icode = v.icode; in_ifun = v.ifun; in_rA = v.ra; in_rB = v.rb;
      in_valC  = v.valc;
      if (v.exp_kind == K_OK) push_expected(v, model_next);
      @(negedge clk);                       // cycle after acceptance
      in_valid = 1'b0;
      if (v.exp_kind == K_OK && v.exp_len > 1) begin
         // Garbage on the inputs during emission must not disturb it.
         in_valid = 1'b1; addr_load = 1'b1; addr_in = 10'h3AA;
         in_icode = 4'h6; in_ifun = 4'h5; in_rA = 4'h7; in_rB = 4'h7;
         in_valC  = {$urandom, $urandom};
      end
      cycles = 0;
      while (!(done === 1'b1 || err_icode === 1'b1 || err_ovf === 1'b1) && cycles < 15) begin
         @(negedge clk);
         cycles++;
      end
      in_valid = 1'b0; addr_load = 1'b0;
      if (v.exp_kind == K_OK) begin
         chk("done", {63'd0, done}, 64'd1);
         chk("done_cycle", 64'(cycles), 64'(v.exp_len - 1));
         chk("done_len", {60'd0, done_len}, 64'(v.exp_len));
         chk("err_flags", {62'd0, err_icode, err_ovf}, 64'd0);
         model_next = model_next + 10'(v.exp_len);
      end else begin
         chk("err_cycle", 64'(cycles), 64'd0);
         chk("err_icode", {63'd0, err_icode}, (v.exp_kind == K_ICOD) ? 64'd1 : 64'd0);
         chk("err_ovf", {63'd0, err_ovf}, (v.exp_kind == K_OVF) ? 64'd1 : 64'd0);
         chk("err_done", {63'd0, done}, 64'd0);
         chk("err_mem_we", {63'd0, mem_we}, 64'd0);
      end
      chk("next_addr", {54'd0, next_addr}, {54'd0, model_next});
      $display("instr icode=%h ifun=%h len=%0d kind=%0d next_addr=0x%03h done_len=%0d",
               v.icode, v.ifun, v.exp_len, v.exp_kind, next_addr, done_len);
      @(negedge clk);
      #1;
      chk("pulse_cleared", {61'd0, done, err_icode, err_ovf}, 64'd0);
      chk("ready_after", {63'd0, in_ready}, 64'd1);
      chk("write_count", 64'(wr_count), (v.exp_kind == K_OK) ? 64'(v.exp_len) : 64'd0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      vec_t rv;
      int   cyc;
      vecs[0]  = '{4'h1, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b0, 10'd0,    1,  K_OK};
      vecs[1]  = '{4'h3, 4'h0, 4'hF, 4'h2, 64'h0102,                1'b1, 10'h010,  10, K_OK};
      vecs[2]  = '{4'h7, 4'h1, 4'h0, 4'h0, 64'h40,                  1'b1, 10'd0,    9,  K_OK};
      vecs[3]  = '{4'hC, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b0, 10'd0,    0,  K_ICOD};
      vecs[4]  = '{4'h6, 4'h0, 4'h1, 4'h2, 64'h0,                   1'b1, 10'd1020, 2,  K_OK};
      vecs[5]  = '{4'h3, 4'h0, 4'hF, 4'h3, 64'h55,                  1'b0, 10'd0,    10, K_OVF};
      vecs[6]  = '{4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b1, 10'h100,  1,  K_OK};
      vecs[7]  = '{4'h9, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b0, 10'd0,    1,  K_OK};
      vecs[8]  = '{4'h2, 4'h3, 4'h4, 4'h5, 64'h0,                   1'b0, 10'd0,    2,  K_OK};
      vecs[9]  = '{4'h5, 4'h0, 4'h6, 4'h7, 64'h1122334455667788,    1'b0, 10'd0,    10, K_OK};
      vecs[10] = '{4'h8, 4'h0, 4'h0, 4'h0, 64'h0123456789ABCDEF,    1'b0, 10'd0,    9,  K_OK};
      vecs[11] = '{4'hA, 4'h0, 4'h8, 4'hF, 64'h0,                   1'b0, 10'd0,    2,  K_OK};
      vecs[12] = '{4'hB, 4'h0, 4'h9, 4'hF, 64'h0,                   1'b0, 10'd0,    2,  K_OK};
      vecs[13] = '{4'hF, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b0, 10'd0,    0,  K_ICOD};
      vecs[14] = '{4'h4, 4'h0, 4'h1, 4'h2, 64'hDEAD,                1'b1, 10'd1013, 10, K_OK};
      vecs[15] = '{4'h6, 4'h1, 4'h3, 4'h4, 64'h0,                   1'b0, 10'd0,    2,  K_OVF};
      vecs[16] = '{4'h1, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b1, 10'd1022, 1,  K_OK};
      vecs[17] = '{4'h5, 4'h0, 4'h1, 4'h2, 64'h77,                  1'b1, 10'd1015, 10, K_OVF};
      vecs[18] = '{4'hD, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b0, 10'd0,    0,  K_ICOD};

      rst_n = 1'b0; in_valid = 1'b0; addr_load = 1'b0; addr_in = 10'd0;
      in_icode = 4'h0; in_ifun = 4'h0; in_rA = 4'h0; in_rB = 4'h0; in_valC = 64'd0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {mem_we, mem_addr, mem_wdata, next_addr, done, done_len,
                          err_icode, err_ovf}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_idle_we", {63'd0, mem_we}, 64'd0);

      for (int i = 0; i < 19; i++) begin
         if (vecs[i].do_load) do_addr_load(vecs[i].load_addr);
         run_instr(vecs[i]);
      end

      // Reset in the middle of an rmmovq, during its 5th byte.
      do_addr_load(10'h020);
      rv = '{4'h4, 4'h0, 4'h3, 4'h5, 64'hCAFE, 1'b0, 10'd0, 10, K_OK};
      @(negedge clk);
      in_valid = 1'b1;
      in_icode = rv.icode; in_ifun = rv.ifun; in_rA = rv.ra; in_rB = rv.rb;
      in_valC = rv.valc;
      push_expected(rv, model_next);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!(mem_we === 1'b1 && mem_addr == 10'h024) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("fifth_byte_seen", 64'(cyc), 64'd4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_we", {63'd0, mem_we}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_next_addr", {54'd0, next_addr}, 64'd0);
      exp_q.delete();
      model_next = 10'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
      chk("post_rst_done", {62'd0, done, mem_we}, 64'd0);
      $display("reset abort next_addr=0x%03h in_ready=%0b", next_addr, in_ready);
      run_instr(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
